// File: rtl/mem_sim_pkg.sv
// Shared types and constants for the I-cache backing-memory model.
// Provides the FSM state enum and line geometry constants.
package mem_sim_pkg;

    localparam int LINE_BITS      = 128;
    localparam int WORD_BITS      = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_line_gen.sv
// Combinational line generator: each word holds its own byte address ^ seed.
// Ports: i_addr (line address [31:4]), o_line (128-bit line, word 0 in LSBs).
module mem_line_gen
    import mem_sim_pkg::*;
#(
    parameter logic [31:0] DATA_SEED = 32'h0000_0000
) (
    input  logic [31-OFFSET_BITS:0] i_addr,
    output logic [LINE_BITS-1:0]    o_line
);

    always_comb begin
        o_line = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            o_line[i*WORD_BITS +: WORD_BITS] =
                {i_addr, 2'(i), 2'b00} ^ DATA_SEED;
        end
    end

endmodule

// File: rtl/icache_mem_sim.sv
// Backing-memory model for the I-cache: one refill at a time, fixed latency.
// Ports: clk, rst_n, mem_req/mem_addr in; mem_data_in/mem_ready out (registered).
module icache_mem_sim
    import mem_sim_pkg::*;
#(
    parameter int          LATENCY   = 4,
    parameter logic [31:0] DATA_SEED = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_req,
    input  logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_data_in,
    output logic                 mem_ready
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    mem_state_e             r_state;
    mem_state_e             w_state_nxt;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
    logic [31-OFFSET_BITS:0] r_addr;
    logic [31-OFFSET_BITS:0] w_addr_nxt;
    logic [LINE_BITS-1:0]   r_data;
    logic                   r_ready;
    logic [LINE_BITS-1:0]   w_line;
    logic                   w_unused;

    // Byte offset within the line never affects the returned data.
    assign w_unused = ^mem_addr[OFFSET_BITS-1:0];

    mem_line_gen #(
        .DATA_SEED (DATA_SEED)
    ) u_line_gen (
        .i_addr (r_addr),
        .o_line (w_line)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        unique case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_addr_nxt  = mem_addr[31:OFFSET_BITS];
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Output pulse is registered on the edge that leaves RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_ready <= (r_state == RESP);
            r_data  <= (r_state == RESP) ? w_line : '0;
        end
    end

    assign mem_ready   = r_ready;
    assign mem_data_in = r_data;

endmodule

// File: tb/tb_icache_mem_sim.sv
// Scoreboard bench for icache_mem_sim.
// Two instances: LATENCY=4/seed 0 and LATENCY=1/seed A5A5A5A5.
module tb_icache_mem_sim;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_a;
    logic [31:0]  addr_a;
    logic [127:0] data_a;
    logic         rdy_a;
    logic         req_b;
    logic [31:0]  addr_b;
    logic [127:0] data_b;
    logic         rdy_b;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    localparam logic [31:0] SEED_B = 32'hA5A5_A5A5;

    icache_mem_sim #(
        .LATENCY   (4),
        .DATA_SEED (32'h0000_0000)
    ) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (req_a),
        .mem_addr    (addr_a),
        .mem_data_in (data_a),
        .mem_ready   (rdy_a)
    );

    icache_mem_sim #(
        .LATENCY   (1),
        .DATA_SEED (SEED_B)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (req_b),
        .mem_addr    (addr_b),
        .mem_data_in (data_b),
        .mem_ready   (rdy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] a,
                                             input logic [31:0] seed);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[32*i +: 32] = {a[31:4], 4'(i * 4)} ^ seed;
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rdy_a) begin
            if (q_a.size() == 0) begin
                check("a_spurious", 128'd1, 128'd0);
            end else begin
                e = q_a.pop_front();
                check("a_data", data_a, e.data);
                check("a_due", 128'(cyc), 128'(e.due));
            end
        end else begin
            check("a_zero", data_a, 128'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rdy_b) begin
            if (q_b.size() == 0) begin
                check("b_spurious", 128'd1, 128'd0);
            end else begin
                e = q_b.pop_front();
                check("b_data", data_b, e.data);
                check("b_due", 128'(cyc), 128'(e.due));
            end
        end else begin
            check("b_zero", data_b, 128'd0);
        end
    end

    initial begin
        int          k;
        int          d;
        logic [31:0] a;

        rst_n  = 1'b0;
        req_a  = 1'b0;
        addr_a = '0;
        req_b  = 1'b0;
        addr_b = '0;
        #1;
        check("rst_rdy_a", 128'(rdy_a), 128'd0);
        check("rst_dat_a", data_a, 128'd0);
        check("rst_rdy_b", 128'(rdy_b), 128'd0);
        check("rst_dat_b", data_b, 128'd0);
        idle(2);
        #2 rst_n = 1'b1;

        // reset while a request is in flight: no response may follow
        @(negedge clk);
        req_a  = 1'b1;
        addr_a = 32'h0000_1000;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 128'(rdy_a), 128'd0);
        check("mid_rst_dat", data_a, 128'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(8);

        // basic read, LATENCY=4
        @(negedge clk);
        k      = cyc;
        req_a  = 1'b1;
        addr_a = 32'h1234_5678;
        q_a.push_back('{128'h1234567C_12345678_12345674_12345670, k + 5});
        @(negedge clk);
        req_a = 1'b0;
        idle(8);

        // offset ignored, seed applied, LATENCY=1
        @(negedge clk);
        k      = cyc;
        req_b  = 1'b1;
        addr_b = 32'hFFFF_FFFF;
        q_b.push_back('{128'h5A5A5A59_5A5A5A5D_5A5A5A51_5A5A5A55, k + 2});
        @(negedge clk);
        req_b = 1'b0;
        idle(4);

        // busy: address change while waiting is ignored
        @(negedge clk);
        k      = cyc;
        req_a  = 1'b1;
        addr_a = 32'h0000_0100;
        q_a.push_back('{line_of(32'h0000_0100, 32'h0), k + 5});
        @(negedge clk);
        addr_a = 32'h0000_0200;
        idle(2);
        req_a = 1'b0;
        idle(6);

        // back-to-back, LATENCY=1, request held high
        @(negedge clk);
        k     = cyc;
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a      = 32'h4000_0000 + 32'(i) * 32'h0000_0040;
            addr_b = a;
            q_b.push_back('{line_of(a, SEED_B), k + 2 + 2 * i});
            @(negedge clk);
            addr_b = 32'hDEAD_BEE0;
            @(negedge clk);
        end
        req_b = 1'b0;
        idle(4);

        // reset asserted while the response is on the outputs
        @(negedge clk);
        k      = cyc;
        req_a  = 1'b1;
        addr_a = 32'h0000_3000;
        q_a.push_back('{line_of(32'h0000_3000, 32'h0), k + 5});
        @(negedge clk);
        req_a = 1'b0;
        while (cyc < k + 5) @(negedge clk);
        check("resp_seen", 128'(rdy_a), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdy", 128'(rdy_a), 128'd0);
        check("async_dat", data_a, 128'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(4);

        // random 15-unit pulses spaced ~100 units apart
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            k      = cyc;
            d      = int'($urandom_range(1, 4));
            a      = $urandom;
            #(d);
            req_a  = 1'b1;
            addr_a = a;
            q_a.push_back('{line_of(a, 32'h0), k + 5});
            #15;
            req_a = 1'b0;
            #80;
        end
        idle(10);

        check("a_left", 128'(q_a.size()), 128'd0);
        check("b_left", 128'(q_b.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
